// File: rtl/rx_cmd_ctrl_pkg.sv
// Shared constants and types for the rx_buffer command decoder: ASCII codes,
// FSM encoding, command kinds and parameter defaults.
package rx_cmd_ctrl_pkg;

   localparam int DUTY_MAX_DEF   = 100;
   localparam int PERIOD_RST_DEF = 1000;

   localparam logic [7:0] ASCII_LF = 8'h0A;
   localparam logic [7:0] ASCII_D  = 8'h44;
   localparam logic [7:0] ASCII_P  = 8'h50;
   localparam logic [7:0] ASCII_E  = 8'h45;
   localparam logic [7:0] ASCII_0  = 8'h30;
   localparam logic [7:0] ASCII_9  = 8'h39;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_RD_REQ,
      ST_RD_CAP,
      ST_APPLY,
      ST_FLUSH
   } state_e;

   typedef enum logic [1:0] {
      CMD_NONE,
      CMD_DUTY,
      CMD_PERIOD,
      CMD_EN
   } cmd_e;

   function automatic logic is_digit(input logic [7:0] b);
      return (b >= ASCII_0) && (b <= ASCII_9);
   endfunction

endpackage

// File: rtl/rx_cmd_ctrl_dec_acc.sv
// 17-bit decimal accumulator (acc = acc*10 + digit). ovf_o flags, for the
// digit currently presented, that loading it would push the value past 65535.
module dec_acc (
   input  logic        clk_i,
   input  logic        rst_ni,
   input  logic        clr_i,
   input  logic        ld_i,
   input  logic [3:0]  digit_i,
   output logic [16:0] acc_o,
   output logic        ovf_o
);

   logic [16:0] acc_q;
   logic [20:0] sum;

   assign sum   = ({4'b0, acc_q} * 21'd10) + {17'b0, digit_i};
   assign ovf_o = (sum > 21'd65535);
   assign acc_o = acc_q;

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         acc_q <= '0;
      end else if (clr_i) begin
         acc_q <= '0;
      end else if (ld_i) begin
         acc_q <= sum[16:0];
      end
   end

endmodule

// File: rtl/rx_cmd_ctrl.sv
// Reads command lines ("D50\n", "P2500\n", "E1\n") out of rx_buffer, one byte
// every two cycles, and updates the PWM configuration registers.
module rx_cmd_ctrl
   import rx_cmd_ctrl_pkg::*;
#(
   parameter int DUTY_MAX   = DUTY_MAX_DEF,
   parameter int PERIOD_RST = PERIOD_RST_DEF
) (
   input  logic        clk_i,
   input  logic        rst_ni,
   input  logic        rx_empty_i,
   input  logic        rx_eos_i,
   input  logic [7:0]  rx_data_i,
   output logic        rx_rd_en_o,
   output logic [7:0]  duty_o,
   output logic [15:0] period_o,
   output logic        pwm_en_o,
   output logic        cfg_upd_o,
   output logic        cmd_err_o,
   output logic        busy_o
);

   state_e      state_q, state_d;
   cmd_e        cmd_q, cmd_d;
   logic [2:0]  ndig_q, ndig_d;
   logic        flush_cap_q, flush_cap_d;
   logic [2:0]  pend_q, pend_d;
   logic        eos_q;
   logic [7:0]  duty_q, duty_d;
   logic [15:0] period_q, period_d;
   logic        pwm_en_q, pwm_en_d;
   logic        err_q, err_d;
   logic        acc_clr, acc_ld, acc_ovf;
   logic [16:0] acc;
   logic        lf_consumed, eos_rise, line_ok, rd_en;

   dec_acc u_dec_acc (
      .clk_i   (clk_i),
      .rst_ni  (rst_ni),
      .clr_i   (acc_clr),
      .ld_i    (acc_ld),
      .digit_i (rx_data_i[3:0]),
      .acc_o   (acc),
      .ovf_o   (acc_ovf)
   );

   always_comb begin
      line_ok = 1'b0;
      if (ndig_q != 3'd0) begin
         unique case (cmd_q)
            CMD_DUTY:   line_ok = (acc <= 17'(DUTY_MAX));
            CMD_PERIOD: line_ok = (acc != 17'd0);
            CMD_EN:     line_ok = (acc <= 17'd1);
            default:    line_ok = 1'b0;
         endcase
      end
   end

   always_comb begin
      state_d     = state_q;
      cmd_d       = cmd_q;
      ndig_d      = ndig_q;
      flush_cap_d = flush_cap_q;
      duty_d      = duty_q;
      period_d    = period_q;
      pwm_en_d    = pwm_en_q;
      err_d       = 1'b0;
      acc_clr     = 1'b0;
      acc_ld      = 1'b0;
      lf_consumed = 1'b0;
      rd_en       = 1'b0;
      unique case (state_q)
         ST_IDLE: begin
            if ((pend_q != 3'd0) && !rx_empty_i) begin
               state_d = ST_RD_REQ;
               acc_clr = 1'b1;
               cmd_d   = CMD_NONE;
               ndig_d  = 3'd0;
            end
         end
         ST_RD_REQ: begin
            if (!rx_empty_i) begin
               rd_en   = 1'b1;
               state_d = ST_RD_CAP;
            end
         end
         ST_RD_CAP: begin
            // A terminator ends the line here; anything else either extends it or sends us to FLUSH.
            if (rx_data_i == ASCII_LF) begin
               lf_consumed = 1'b1;
               state_d     = ST_IDLE;
               if (cmd_q != CMD_NONE) begin
                  if (!line_ok) begin
                     err_d = 1'b1;
                  end else begin
                     state_d = ST_APPLY;
                     unique case (cmd_q)
                        CMD_DUTY:   duty_d   = acc[7:0];
                        CMD_PERIOD: period_d = acc[15:0];
                        default:    pwm_en_d = acc[0];
                     endcase
                  end
               end
            end else if (cmd_q == CMD_NONE) begin
               state_d = ST_RD_REQ;
               unique case (rx_data_i)
                  ASCII_D: cmd_d = CMD_DUTY;
                  ASCII_P: cmd_d = CMD_PERIOD;
                  ASCII_E: cmd_d = CMD_EN;
                  default: begin
                     state_d     = ST_FLUSH;
                     flush_cap_d = 1'b0;
                  end
               endcase
            end else if (is_digit(rx_data_i) && (ndig_q < 3'd5) && !acc_ovf) begin
               acc_ld  = 1'b1;
               ndig_d  = ndig_q + 3'd1;
               state_d = ST_RD_REQ;
            end else begin
               state_d     = ST_FLUSH;
               flush_cap_d = 1'b0;
            end
         end
         ST_APPLY: begin
            state_d = ST_IDLE;
         end
         ST_FLUSH: begin
            if (!flush_cap_q) begin
               if (!rx_empty_i) begin
                  rd_en       = 1'b1;
                  flush_cap_d = 1'b1;
               end
            end else begin
               flush_cap_d = 1'b0;
               if (rx_data_i == ASCII_LF) begin
                  lf_consumed = 1'b1;
                  err_d       = 1'b1;
                  state_d     = ST_IDLE;
               end
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   // Pending-line count: a new line and a consumed terminator in the same cycle cancel out.
   always_comb begin
      eos_rise = rx_eos_i & ~eos_q;
      pend_d   = pend_q;
      if (eos_rise && !lf_consumed && (pend_q != 3'd7)) begin
         pend_d = pend_q + 3'd1;
      end else if (lf_consumed && !eos_rise && (pend_q != 3'd0)) begin
         pend_d = pend_q - 3'd1;
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q     <= ST_IDLE;
         cmd_q       <= CMD_NONE;
         ndig_q      <= 3'd0;
         flush_cap_q <= 1'b0;
         pend_q      <= 3'd0;
         eos_q       <= 1'b0;
         duty_q      <= 8'd0;
         period_q    <= 16'(PERIOD_RST);
         pwm_en_q    <= 1'b0;
         err_q       <= 1'b0;
      end else begin
         state_q     <= state_d;
         cmd_q       <= cmd_d;
         ndig_q      <= ndig_d;
         flush_cap_q <= flush_cap_d;
         pend_q      <= pend_d;
         eos_q       <= rx_eos_i;
         duty_q      <= duty_d;
         period_q    <= period_d;
         pwm_en_q    <= pwm_en_d;
         err_q       <= err_d;
      end
   end

   assign rx_rd_en_o = rd_en;
   assign duty_o     = duty_q;
   assign period_o   = period_q;
   assign pwm_en_o   = pwm_en_q;
   assign cfg_upd_o  = (state_q == ST_APPLY);
   assign cmd_err_o  = err_q;
   assign busy_o     = (state_q != ST_IDLE);

endmodule

// File: tb/tb_rx_cmd_ctrl.sv
// Bench for rx_cmd_ctrl: a behavioural rx_buffer model feeds command lines and
// a scoreboard of expected cfg_upd / cmd_err events is checked as pulses appear.
module tb_rx_cmd_ctrl;

   typedef struct {
      bit          isErr;
      logic [7:0]  duty;
      logic [15:0] period;
      logic        pwmEn;
   } exp_t;

   logic        clk = 1'b0;
   logic        rstN = 1'b0;
   logic        rxEmpty = 1'b1;
   logic        rxEos = 1'b0;
   logic [7:0]  rxData = 8'h00;
   logic        rxRdEn;
   logic [7:0]  duty;
   logic [15:0] period;
   logic        pwmEn;
   logic        cfgUpd;
   logic        cmdErr;
   logic        busy;

   logic [7:0]  fifo[$];
   exp_t        expQ[$];
   int          checks = 0;
   int          errors = 0;
   int          popCount = 0;
   int          pulseCount = 0;
   logic [7:0]  mDuty = 8'd0;
   logic [15:0] mPeriod = 16'd1000;
   logic        mPwmEn = 1'b0;

   rx_cmd_ctrl #(.DUTY_MAX(100), .PERIOD_RST(1000)) dut (
      .clk_i      (clk),
      .rst_ni     (rstN),
      .rx_empty_i (rxEmpty),
      .rx_eos_i   (rxEos),
      .rx_data_i  (rxData),
      .rx_rd_en_o (rxRdEn),
      .duty_o     (duty),
      .period_o   (period),
      .pwm_en_o   (pwmEn),
      .cfg_upd_o  (cfgUpd),
      .cmd_err_o  (cmdErr),
      .busy_o     (busy)
   );

   always #5 clk = ~clk;

   // rx_buffer model: read data appears the cycle after the strobe is sampled
   always @(posedge clk) begin
      if (rstN && rxRdEn) begin
         if (fifo.size() == 0) begin
            checks++;
            errors++;
            $display("[TB] FAIL read_empty: rd_en=1 with buffer size 0, required no read");
         end else begin
            rxData <= fifo.pop_front();
            popCount++;
         end
      end
   end

   always @(negedge clk) begin
      rxEmpty <= (fifo.size() == 0);
   end

   // Scoreboard: every pulse must match the oldest expected event
   always @(negedge clk) begin
      if (rstN && (cfgUpd || cmdErr)) begin
         exp_t e;
         pulseCount++;
         checks++;
         if (expQ.size() == 0) begin
            errors++;
            $display("[TB] FAIL unexpected_pulse: cfg_upd=%0b cmd_err=%0b, required none", cfgUpd, cmdErr);
         end else begin
            e = expQ.pop_front();
            if ((cmdErr !== e.isErr) || (cfgUpd !== !e.isErr) || (duty !== e.duty)
                || (period !== e.period) || (pwmEn !== e.pwmEn)) begin
               errors++;
               $display("[TB] FAIL event: got err=%0b upd=%0b duty=%0d period=%0d en=%0b, required err=%0b upd=%0b duty=%0d period=%0d en=%0b",
                        cmdErr, cfgUpd, duty, period, pwmEn, e.isErr, !e.isErr, e.duty, e.period, e.pwmEn);
            end
         end
      end
   end

   // Independent line model: decides accept/reject and pushes the expected event
   task automatic expect_line(input string s);
      int   n;
      int   val;
      int   nd;
      bit   err;
      byte  c;
      exp_t e;
      n   = s.len();
      val = 0;
      nd  = 0;
      err = 0;
      if (n == 1 && s[0] == 8'h0A) return;
      c = s[0];
      if (c != "D" && c != "P" && c != "E") err = 1;
      for (int i = 1; i < n - 1; i++) begin
         if (s[i] >= "0" && s[i] <= "9") begin
            nd++;
            if (nd <= 5) val = val * 10 + (s[i] - 8'h30);
         end else begin
            err = 1;
         end
      end
      if (nd == 0 || nd > 5 || val > 65535) err = 1;
      if (!err) begin
         if (c == "D" && val > 100) err = 1;
         if (c == "P" && val == 0) err = 1;
         if (c == "E" && val > 1) err = 1;
      end
      if (!err) begin
         if (c == "D") mDuty = val[7:0];
         if (c == "P") mPeriod = val[15:0];
         if (c == "E") mPwmEn = val[0];
      end
      e.isErr  = err;
      e.duty   = mDuty;
      e.period = mPeriod;
      e.pwmEn  = mPwmEn;
      expQ.push_back(e);
   endtask

   task automatic push_bytes(input string s);
      @(negedge clk);
      for (int i = 0; i < s.len(); i++) fifo.push_back(s[i]);
   endtask

   task automatic pulse_eos();
      @(negedge clk);
      rxEos = 1'b1;
      @(negedge clk);
      rxEos = 1'b0;
      @(negedge clk);
   endtask

   task automatic write_line(input string s);
      expect_line(s);
      push_bytes(s);
      pulse_eos();
   endtask

   task automatic wait_idle(input string name);
      bit done;
      done = 0;
      for (int i = 0; i < 3000 && !done; i++) begin
         @(negedge clk);
         if (fifo.size() == 0 && !busy && expQ.size() == 0) done = 1;
      end
      repeat (4) @(negedge clk);
      checks++;
      if (!done || expQ.size() != 0) begin
         errors++;
         $display("[TB] FAIL %s_timeout: busy=%0b fifo=%0d pending_events=%0d, required all 0",
                  name, busy, fifo.size(), expQ.size());
      end
   endtask

   task automatic test_reset();
      rstN = 1'b0;
      repeat (3) @(negedge clk);
      checks++;
      if (duty !== 8'd0 || period !== 16'd1000 || pwmEn !== 1'b0 || cfgUpd !== 1'b0
          || cmdErr !== 1'b0 || rxRdEn !== 1'b0 || busy !== 1'b0) begin
         errors++;
         $display("[TB] FAIL reset_values: duty=%0d period=%0d en=%0b upd=%0b err=%0b rd=%0b busy=%0b, required 0/1000/0/0/0/0/0",
                  duty, period, pwmEn, cfgUpd, cmdErr, rxRdEn, busy);
      end
      rstN = 1'b1;
      repeat (2) @(negedge clk);
   endtask

   task automatic test_duty();
      int p0;
      p0 = pulseCount;
      write_line("D50\n");
      wait_idle("duty");
      checks++;
      if (duty !== 8'd50 || period !== 16'd1000 || pwmEn !== 1'b0 || pulseCount - p0 != 1) begin
         errors++;
         $display("[TB] FAIL duty_final: duty=%0d period=%0d en=%0b pulses=%0d, required 50/1000/0/1",
                  duty, period, pwmEn, pulseCount - p0);
      end
   endtask

   task automatic test_back_to_back();
      expect_line("P2500\n");
      expect_line("E1\n");
      push_bytes("P2500\nE1\n");
      pulse_eos();
      pulse_eos();
      wait_idle("b2b");
      checks++;
      if (period !== 16'd2500 || pwmEn !== 1'b1 || duty !== 8'd50) begin
         errors++;
         $display("[TB] FAIL b2b_final: period=%0d en=%0b duty=%0d, required 2500/1/50", period, pwmEn, duty);
      end
      checks++;
      if (dut.pend_q !== 3'd0) begin
         errors++;
         $display("[TB] FAIL b2b_pending: pending=%0d, required 0", dut.pend_q);
      end
   endtask

   task automatic test_errors();
      write_line("D101\n");
      write_line("P0\n");
      write_line("E2\n");
      write_line("P70000\n");
      write_line("D12a\n");
      write_line("E\n");
      wait_idle("errors");
      checks++;
      if (duty !== 8'd50 || period !== 16'd2500 || pwmEn !== 1'b1) begin
         errors++;
         $display("[TB] FAIL errors_hold: duty=%0d period=%0d en=%0b, required 50/2500/1", duty, period, pwmEn);
      end
   endtask

   task automatic test_flush();
      int c0;
      c0 = popCount;
      expect_line("X12\n");
      expect_line("D7\n");
      push_bytes("X12\nD7\n");
      pulse_eos();
      pulse_eos();
      wait_idle("flush");
      checks++;
      if (duty !== 8'd7 || popCount - c0 != 7) begin
         errors++;
         $display("[TB] FAIL flush_final: duty=%0d bytes_read=%0d, required 7/7", duty, popCount - c0);
      end
   endtask

   task automatic test_empty_line();
      int p0;
      p0 = pulseCount;
      write_line("\n");
      wait_idle("empty");
      checks++;
      if (pulseCount != p0 || busy !== 1'b0) begin
         errors++;
         $display("[TB] FAIL empty_line: pulses=%0d busy=%0b, required 0/0", pulseCount - p0, busy);
      end
   endtask

   task automatic test_stall();
      expect_line("D8\n");
      push_bytes("D8");
      pulse_eos();
      repeat (20) @(negedge clk);
      checks++;
      if (busy !== 1'b1 || rxRdEn !== 1'b0 || duty !== 8'd7) begin
         errors++;
         $display("[TB] FAIL stall: busy=%0b rd_en=%0b duty=%0d, required 1/0/7", busy, rxRdEn, duty);
      end
      push_bytes("\n");
      wait_idle("stall");
      checks++;
      if (duty !== 8'd8) begin
         errors++;
         $display("[TB] FAIL stall_final: duty=%0d, required 8", duty);
      end
   endtask

   task automatic test_reset_midline();
      int  c0;
      bit  seen;
      c0   = popCount;
      seen = 0;
      push_bytes("D3\n");
      pulse_eos();
      for (int i = 0; i < 200 && !seen; i++) begin
         if (popCount - c0 >= 2) seen = 1;
         else @(negedge clk);
      end
      checks++;
      if (!seen) begin
         errors++;
         $display("[TB] FAIL midline_reads: bytes_read=%0d, required 2", popCount - c0);
      end
      rstN = 1'b0;
      fifo.delete();
      expQ.delete();
      mDuty   = 8'd0;
      mPeriod = 16'd1000;
      mPwmEn  = 1'b0;
      #1;
      checks++;
      if (duty !== 8'd0 || period !== 16'd1000 || pwmEn !== 1'b0 || cfgUpd !== 1'b0
          || cmdErr !== 1'b0 || rxRdEn !== 1'b0 || busy !== 1'b0) begin
         errors++;
         $display("[TB] FAIL midline_reset: duty=%0d period=%0d en=%0b upd=%0b err=%0b rd=%0b busy=%0b, required 0/1000/0/0/0/0/0",
                  duty, period, pwmEn, cfgUpd, cmdErr, rxRdEn, busy);
      end
      repeat (2) @(negedge clk);
      rstN = 1'b1;
      @(posedge clk);
      #1;
      checks++;
      if (busy !== 1'b0 || cfgUpd !== 1'b0 || cmdErr !== 1'b0) begin
         errors++;
         $display("[TB] FAIL midline_after: busy=%0b upd=%0b err=%0b, required 0/0/0", busy, cfgUpd, cmdErr);
      end
      write_line("D9\n");
      wait_idle("post_reset");
      checks++;
      if (duty !== 8'd9 || period !== 16'd1000) begin
         errors++;
         $display("[TB] FAIL post_reset_line: duty=%0d period=%0d, required 9/1000", duty, period);
      end
   endtask

   initial begin
      $display("[TB] starting rx_cmd_ctrl bench");
      test_reset();
      test_duty();
      test_back_to_back();
      test_errors();
      test_flush();
      test_empty_line();
      test_stall();
      test_reset_midline();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
